width_conv_fifo: RTL and testbench

Single-clock FIFO that converts between any two power-of-two data widths, narrowing (wide in, narrow out) or widening (narrow in, wide out), with valid/ready handshakes on both sides. It is the generalised successor of the team's fixed-ratio narrowing FIFO: it adds widening mode, ratios up to 16, first-word fall-through reads, a granule occupancy count, and a synchronous flush. It sits between datapath stages of different bus widths inside one clock domain.

---
 rtl/width_conv_fifo.sv | 115 +++++++++++
 tb/tb_width_conv_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/width_conv_fifo.sv
// width_conv_fifo
//   Single-clock FIFO between two power-of-two data widths. Storage is kept
//   in granules of min(WR_WIDTH, RD_WIDTH) bits, so narrowing and widening
//   share one datapath: a write stores WR_G granules, a read consumes RD_G.
//   Granule order is little-endian on both sides. Reads are first-word
//   fall-through.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   flush_i                synchronous clear of all contents
//   wr_valid_i/wr_ready_o  write handshake, wr_data_i is WR_WIDTH bits
//   rd_valid_o/rd_ready_i  read handshake, rd_data_o is the head word
//   count_o                occupancy in granules
//   empty_o, full_o        count_o == 0 / count_o == capacity
module width_conv_fifo #(
    parameter int DEPTH_LG2 = 4,
    parameter int WR_WIDTH  = 32,
    parameter int RD_WIDTH  = 8,
    parameter bit RST_MEM   = 1'b0,
    localparam int MAXW  = (WR_WIDTH > RD_WIDTH) ? WR_WIDTH : RD_WIDTH,
    localparam int G     = (WR_WIDTH < RD_WIDTH) ? WR_WIDTH : RD_WIDTH,
    localparam int WR_G  = WR_WIDTH / G,
    localparam int RD_G  = RD_WIDTH / G,
    localparam int R_LG2 = $clog2(MAXW / G),
    localparam int AW    = DEPTH_LG2 + R_LG2,
    localparam int PW    = AW + 1,
    localparam int CAP   = 1 << AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                wr_valid_i,
    input  logic [WR_WIDTH-1:0] wr_data_i,
    output logic                wr_ready_o,
    output logic                rd_valid_o,
    input  logic                rd_ready_i,
    output logic [RD_WIDTH-1:0] rd_data_o,
    output logic [PW-1:0]       count_o,
    output logic                empty_o,
    output logic                full_o
);

    localparam logic [PW-1:0] CAP_P  = PW'(CAP);
    localparam logic [PW-1:0] WR_GP  = PW'(WR_G);
    localparam logic [PW-1:0] RD_GP  = PW'(RD_G);

    logic [G-1:0]  mem_q [CAP];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          wr_fire, rd_fire;

    // Flow control is decoded from the registered count only, so neither
    // handshake input reaches an output combinationally.
    assign wr_ready_o = (CAP_P - count_q) >= WR_GP;
    assign rd_valid_o = count_q >= RD_GP;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CAP_P);
    assign count_o    = count_q;

    assign wr_fire = wr_valid_i & wr_ready_o;
    assign rd_fire = rd_valid_o & rd_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + WR_GP;
        if (rd_fire) rd_ptr_d = rd_ptr_q + RD_GP;
        count_d = count_q + (wr_fire ? WR_GP : '0) - (rd_fire ? RD_GP : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // WR_G and RD_G divide CAP and pointers advance in whole words, so a
    // word never straddles the address wrap; low pointer bits index directly.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            if (RST_MEM) begin
                for (int i = 0; i < CAP; i++) mem_q[i] <= '0;
            end
        end else if (wr_fire) begin
            for (int i = 0; i < WR_G; i++)
                mem_q[wr_ptr_q[AW-1:0] + AW'(i)] <= wr_data_i[i*G +: G];
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < RD_G; i++)
            rd_data_o[i*G +: G] = mem_q[rd_ptr_q[AW-1:0] + AW'(i)];
    end

`ifndef SYNTHESIS
    // Protocol warnings for the surrounding logic; they never stop the run.
    always @(posedge clk) begin
        if (rst_n && !flush_i) begin
            if (wr_valid_i && !wr_ready_o)
                $warning("width_conv_fifo: write requested without room");
            if (rd_ready_i && !rd_valid_o)
                $warning("width_conv_fifo: read requested with no full word");
        end
    end
`endif

endmodule

// File: tb/tb_width_conv_fifo.sv
// Bench for width_conv_fifo: four instances (32->8, 8->32 with cleared
// storage, 32->32, 128->8) checked against a granule-queue model.
module tb_width_conv_fifo;

    localparam int WRW [4] = '{32, 8, 32, 128};
    localparam int RDW [4] = '{8, 32, 32, 8};
    localparam int DLG [4] = '{2, 2, 4, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         wv [4];
    logic         rr [4];
    logic         fl [4];
    logic [127:0] wd [4];
    logic         rv [4];
    logic         wrdy [4];
    logic         emp [4];
    logic         ful [4];
    logic [127:0] rdat [4];
    logic [127:0] cnt [4];

    logic [7:0]  a_rd;  logic [4:0] a_cnt;
    logic [31:0] b_rd;  logic [4:0] b_cnt;
    logic [31:0] c_rd;  logic [4:0] c_cnt;
    logic [7:0]  d_rd;  logic [8:0] d_cnt;

    assign rdat[0] = 128'(a_rd);  assign cnt[0] = 128'(a_cnt);
    assign rdat[1] = 128'(b_rd);  assign cnt[1] = 128'(b_cnt);
    assign rdat[2] = 128'(c_rd);  assign cnt[2] = 128'(c_cnt);
    assign rdat[3] = 128'(d_rd);  assign cnt[3] = 128'(d_cnt);

    width_conv_fifo #(.DEPTH_LG2(2), .WR_WIDTH(32), .RD_WIDTH(8), .RST_MEM(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .flush_i(fl[0]), .wr_valid_i(wv[0]), .wr_data_i(wd[0][31:0]),
        .wr_ready_o(wrdy[0]), .rd_valid_o(rv[0]), .rd_ready_i(rr[0]), .rd_data_o(a_rd),
        .count_o(a_cnt), .empty_o(emp[0]), .full_o(ful[0]));

    width_conv_fifo #(.DEPTH_LG2(2), .WR_WIDTH(8), .RD_WIDTH(32), .RST_MEM(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .flush_i(fl[1]), .wr_valid_i(wv[1]), .wr_data_i(wd[1][7:0]),
        .wr_ready_o(wrdy[1]), .rd_valid_o(rv[1]), .rd_ready_i(rr[1]), .rd_data_o(b_rd),
        .count_o(b_cnt), .empty_o(emp[1]), .full_o(ful[1]));

    width_conv_fifo #(.DEPTH_LG2(4), .WR_WIDTH(32), .RD_WIDTH(32), .RST_MEM(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .flush_i(fl[2]), .wr_valid_i(wv[2]), .wr_data_i(wd[2][31:0]),
        .wr_ready_o(wrdy[2]), .rd_valid_o(rv[2]), .rd_ready_i(rr[2]), .rd_data_o(c_rd),
        .count_o(c_cnt), .empty_o(emp[2]), .full_o(ful[2]));

    width_conv_fifo #(.DEPTH_LG2(4), .WR_WIDTH(128), .RD_WIDTH(8), .RST_MEM(1'b0)) u_d (
        .clk(clk), .rst_n(rst_n), .flush_i(fl[3]), .wr_valid_i(wv[3]), .wr_data_i(wd[3]),
        .wr_ready_o(wrdy[3]), .rd_valid_o(rv[3]), .rd_ready_i(rr[3]), .rd_data_o(d_rd),
        .count_o(d_cnt), .empty_o(emp[3]), .full_o(ful[3]));

    // Reference model: the FIFO is just an ordered list of granules.
    bit [31:0] mq [$];
    int nchk = 0;
    int nerr = 0;

    function automatic int gsz(int k);
        return (WRW[k] < RDW[k]) ? WRW[k] : RDW[k];
    endfunction
    function automatic int wrg(int k);  return WRW[k] / gsz(k);  endfunction
    function automatic int rdg(int k);  return RDW[k] / gsz(k);  endfunction
    function automatic int capg(int k);
        int mx;
        mx = (WRW[k] > RDW[k]) ? WRW[k] : RDW[k];
        return (1 << DLG[k]) * (mx / gsz(k));
    endfunction

    function automatic logic [127:0] exp_head(int k);
        logic [127:0] e;
        e = '0;
        for (int i = 0; i < rdg(k); i++) e = e | (128'(mq[i]) << (i * gsz(k)));
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc_check(input int k);
        int sz;
        sz = mq.size();
        chk("count",    cnt[k],  128'(sz));
        chk("empty",    emp[k],  128'(sz == 0));
        chk("full",     ful[k],  128'(sz == capg(k)));
        chk("wr_ready", wrdy[k], 128'(capg(k) - sz >= wrg(k)));
        chk("rd_valid", rv[k],   128'(sz >= rdg(k)));
        if (sz >= rdg(k)) chk("rd_data", rdat[k], exp_head(k));
    endtask

    // One clock of traffic on instance k, starting and ending at a negedge.
    task automatic tick(input int k, input bit v, input bit r, input logic [127:0] d);
        int sz;
        bit wf, rf;
        logic [127:0] gm;
        sz = mq.size();
        gm = (128'(1) << gsz(k)) - 1;
        wv[k] = v;
        wd[k] = d;
        rr[k] = r && (sz >= rdg(k));
        #1;
        chk("comb_wr_ready", wrdy[k], 128'(capg(k) - sz >= wrg(k)));
        chk("comb_rd_valid", rv[k],   128'(sz >= rdg(k)));
        wf = v && (capg(k) - sz >= wrg(k));
        rf = rr[k];
        if (rf) repeat (rdg(k)) void'(mq.pop_front());
        if (wf) for (int i = 0; i < wrg(k); i++) mq.push_back(32'((d >> (i * gsz(k))) & gm));
        @(negedge clk);
        wv[k] = 1'b0;
        rr[k] = 1'b0;
        cyc_check(k);
    endtask

    task automatic flush_op(input int k, input logic [127:0] d);
        fl[k] = 1'b1;
        wv[k] = 1'b1;
        wd[k] = d;
        mq.delete();
        @(negedge clk);
        fl[k] = 1'b0;
        wv[k] = 1'b0;
        cyc_check(k);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wv[k] = 1'b0; rr[k] = 1'b0; fl[k] = 1'b0;
        end
        mq.delete();
        for (int k = 0; k < 4; k++) cyc_check(k);
        chk("rst_mem_data", rdat[1], '0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [7:0] seq [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        int n;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wv[k] = 1'b0; rr[k] = 1'b0; fl[k] = 1'b0; wd[k] = '0;
        end

        // Narrowing 32->8 byte order, drain to empty.
        do_reset();
        tick(0, 1'b1, 1'b1, 128'hDDCCBBAA);
        n = 0;
        for (int c = 0; c < 20 && n < 8; c++) begin
            if (rv[0]) begin
                chk("nar_seq", rdat[0], 128'(seq[n]));
                n++;
            end
            tick(0, c == 0, 1'b1, 128'h44332211);
        end
        chk("nar_reads", 128'(n), 128'd8);
        chk("nar_empty", emp[0], 128'd1);

        // Widening 8->32: partial word held, then flush with a write pending.
        do_reset();
        tick(1, 1'b1, 1'b0, 128'hAA);
        tick(1, 1'b1, 1'b0, 128'hBB);
        tick(1, 1'b1, 1'b0, 128'hCC);
        chk("wid_cnt3", cnt[1], 128'd3);
        chk("wid_partial_hidden", rv[1], 128'd0);
        tick(1, 1'b1, 1'b0, 128'hDD);
        chk("wid_valid", rv[1], 128'd1);
        chk("wid_word", rdat[1], 128'hDDCCBBAA);
        tick(1, 1'b1, 1'b0, 128'h11);
        chk("wid_cnt5", cnt[1], 128'd5);
        flush_op(1, 128'h22);
        chk("flush_cnt", cnt[1], 128'd0);
        chk("flush_empty", emp[1], 128'd1);
        chk("flush_mem_clear", rdat[1], 128'd0);
        tick(1, 1'b1, 1'b0, 128'h01);
        tick(1, 1'b1, 1'b0, 128'h02);
        tick(1, 1'b1, 1'b0, 128'h03);
        tick(1, 1'b1, 1'b0, 128'h04);
        chk("post_flush_word", rdat[1], 128'h04030201);

        // Fill 32->32 to full, ignored write, then streaming across wrap.
        do_reset();
        for (int i = 0; i < 16; i++) tick(2, 1'b1, 1'b0, 128'($urandom));
        chk("fill_full", ful[2], 128'd1);
        chk("fill_cnt", cnt[2], 128'd16);
        chk("fill_not_ready", wrdy[2], 128'd0);
        tick(2, 1'b1, 1'b0, 128'hDEADBEEF);
        chk("full_write_ignored", cnt[2], 128'd16);
        for (int i = 0; i < 48; i++) tick(2, 1'b1, 1'b1, 128'($urandom));
        chk("stream_cnt", cnt[2], 128'd15);

        // Reset in the middle of a half-full 128->8 FIFO with a write pending.
        do_reset();
        for (int i = 0; i < 8; i++) tick(3, 1'b1, 1'b0, rnd128());
        chk("half_cnt", cnt[3], 128'd128);
        wv[3] = 1'b1;
        wd[3] = rnd128();
        do_reset();
        tick(3, 1'b1, 1'b0, 128'h00112233445566778899AABBCCDDEEFF);
        chk("post_rst_head", rdat[3], 128'hFF);
        tick(3, 1'b0, 1'b1, '0);
        chk("post_rst_next", rdat[3], 128'hEE);

        // Random traffic with occasional flushes on every ratio.
        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int i = 0; i < 400; i++) begin
                bit v, r;
                v = ($urandom_range(0, 3) != 0) && (capg(k) - mq.size() >= wrg(k));
                r = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 99) == 0) flush_op(k, rnd128());
                else tick(k, v, r, rnd128());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

endmodule
